// File: rtl/if_fetch_pkg.sv
// Shared definitions for the fetch stage: bus widths, pipeline hold codes,
// the canonical NOP encoding and the fetch FSM state type.
package if_fetch_pkg;

    localparam int HOLD_BUS = 3;
    localparam int DATA_BUS = 32;
    localparam int ADDR_BUS = 32;

    localparam logic [DATA_BUS-1:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [HOLD_BUS-1:0] {
        HOLD_NONE = 3'd0,
        HOLD_PC   = 3'd1,
        HOLD_IF   = 3'd2,
        HOLD_ID   = 3'd3,
        HOLD_PPL  = 3'd4
    } hold_e;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_WAIT
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer: holds a fetched instruction and its PC while the
// output register is stalled. Flush has priority over push and pop.
module fetch_skid
    import if_fetch_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                push,
    input  logic                pop,
    input  logic [DATA_BUS-1:0] push_data,
    input  logic [ADDR_BUS-1:0] push_addr,
    output logic                full,
    output logic [DATA_BUS-1:0] data,
    output logic [ADDR_BUS-1:0] addr
);

    logic                full_reg;
    logic [DATA_BUS-1:0] data_reg;
    logic [ADDR_BUS-1:0] addr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_reg <= 1'b0;
            data_reg <= INST_NOP;
            addr_reg <= '0;
        end else if (flush) begin
            full_reg <= 1'b0;
        end else if (push) begin
            full_reg <= 1'b1;
            data_reg <= push_data;
            addr_reg <= push_addr;
        end else if (pop) begin
            full_reg <= 1'b0;
        end
    end

    assign full = full_reg;
    assign data = data_reg;
    assign addr = addr_reg;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding req/gnt/rvalid
// bus master and presents one instruction per cycle to the IF/ID register.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [ADDR_BUS-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [DATA_BUS-1:0] NOP_INST = INST_NOP
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [HOLD_BUS-1:0] hold_flag,
    input  logic                jump_flag,
    input  logic [ADDR_BUS-1:0] jump_addr,
    output logic                ibus_req,
    output logic [ADDR_BUS-1:0] ibus_addr,
    input  logic                ibus_gnt,
    input  logic                ibus_rvalid,
    input  logic [DATA_BUS-1:0] ibus_rdata,
    output logic [DATA_BUS-1:0] IF_inst_data,
    output logic [ADDR_BUS-1:0] IF_inst_addr,
    output logic                IF_inst_valid
);

    fetch_state_e        state_reg;
    logic [ADDR_BUS-1:0] pc_reg, pc_next;
    logic                outstanding_reg;
    logic                drop_reg, drop_next;
    logic                req_reg;
    logic [ADDR_BUS-1:0] req_addr_reg;
    logic [DATA_BUS-1:0] out_data_reg;
    logic [ADDR_BUS-1:0] out_addr_reg;
    logic                out_valid_reg;

    logic                stall_out, stop_issue, can_issue;
    logic                granted, resp_done, resp_take, out_free;
    logic                skid_full, skid_push, skid_pop;
    logic [DATA_BUS-1:0] skid_data;
    logic [ADDR_BUS-1:0] skid_addr;

    assign stall_out  = (hold_flag == HOLD_IF) || (hold_flag == HOLD_ID) || (hold_flag == HOLD_PPL);
    assign stop_issue = stall_out || (hold_flag == HOLD_PC);
    assign can_issue  = !stop_issue && !skid_full;

    assign granted   = (state_reg == FETCH_REQ) && ibus_gnt;
    assign resp_done = ibus_rvalid && outstanding_reg;
    // A response that lands together with a jump belongs to the old path.
    assign resp_take = resp_done && !drop_reg && !jump_flag;
    assign out_free  = !out_valid_reg || !stall_out;
    assign skid_push = resp_take && !out_free;
    assign skid_pop  = skid_full && !stall_out && !jump_flag;

    // A grant whose request was overtaken by a jump must not advance the new PC.
    always_comb begin
        pc_next = pc_reg;
        if (jump_flag)
            pc_next = jump_addr;
        else if (granted && !drop_reg)
            pc_next = pc_reg + 32'd4;
    end

    always_comb begin
        drop_next = drop_reg && !resp_done;
        if (jump_flag && ((state_reg == FETCH_REQ) || (outstanding_reg && !ibus_rvalid)))
            drop_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= FETCH_IDLE;
            pc_reg          <= RESET_PC;
            req_reg         <= 1'b0;
            req_addr_reg    <= RESET_PC;
            outstanding_reg <= 1'b0;
            drop_reg        <= 1'b0;
        end else begin
            pc_reg   <= pc_next;
            drop_reg <= drop_next;
            case (state_reg)
                FETCH_IDLE: begin
                    if (can_issue) begin
                        state_reg    <= FETCH_REQ;
                        req_reg      <= 1'b1;
                        req_addr_reg <= pc_next;
                    end
                end
                FETCH_REQ: begin
                    if (ibus_gnt) begin
                        state_reg       <= FETCH_WAIT;
                        req_reg         <= 1'b0;
                        outstanding_reg <= 1'b1;
                    end
                end
                FETCH_WAIT: begin
                    if (ibus_rvalid) begin
                        outstanding_reg <= 1'b0;
                        if (can_issue) begin
                            state_reg    <= FETCH_REQ;
                            req_reg      <= 1'b1;
                            req_addr_reg <= pc_next;
                        end else begin
                            state_reg <= FETCH_IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= FETCH_IDLE;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

    // Output register; req_addr_reg still holds the address of the response in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_reg  <= NOP_INST;
            out_addr_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else if (jump_flag) begin
            out_data_reg  <= NOP_INST;
            out_valid_reg <= 1'b0;
        end else if (skid_pop) begin
            out_data_reg  <= skid_data;
            out_addr_reg  <= skid_addr;
            out_valid_reg <= 1'b1;
        end else if (resp_take && out_free) begin
            out_data_reg  <= ibus_rdata;
            out_addr_reg  <= req_addr_reg;
            out_valid_reg <= 1'b1;
        end else if (!stall_out) begin
            out_data_reg  <= NOP_INST;
            out_valid_reg <= 1'b0;
        end
    end

    fetch_skid u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (jump_flag),
        .push      (skid_push),
        .pop       (skid_pop),
        .push_data (ibus_rdata),
        .push_addr (req_addr_reg),
        .full      (skid_full),
        .data      (skid_data),
        .addr      (skid_addr)
    );

    assign ibus_req      = req_reg;
    assign ibus_addr     = req_addr_reg;
    assign IF_inst_data  = out_data_reg;
    assign IF_inst_addr  = out_addr_reg;
    assign IF_inst_valid = out_valid_reg;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a simple responder (always grants, rdata = addr ^ A5A5_0000,
// configurable latency) and a cycle-exact script checked on the falling clock edge.
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  hold_flag;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt;
    logic        ibus_rvalid = 1'b0;
    logic [31:0] ibus_rdata  = 32'h0;
    logic [31:0] IF_inst_data;
    logic [31:0] IF_inst_addr;
    logic        IF_inst_valid;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat      = 1;
    int          cnt      = 0;
    logic [31:0] pend_addr = 32'h0;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    if_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .hold_flag     (hold_flag),
        .jump_flag     (jump_flag),
        .jump_addr     (jump_addr),
        .ibus_req      (ibus_req),
        .ibus_addr     (ibus_addr),
        .ibus_gnt      (ibus_gnt),
        .ibus_rvalid   (ibus_rvalid),
        .ibus_rdata    (ibus_rdata),
        .IF_inst_data  (IF_inst_data),
        .IF_inst_addr  (IF_inst_addr),
        .IF_inst_valid (IF_inst_valid)
    );

    always #5 clk = ~clk;

    assign ibus_gnt = ibus_req;

    // Responder: rvalid arrives 'lat' cycles after the granting edge; reset discards it.
    always @(posedge clk) begin
        #2;
        ibus_rvalid = 1'b0;
        if (!rst_n) begin
            cnt = 0;
        end else begin
            if (cnt > 0) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    ibus_rvalid = 1'b1;
                    ibus_rdata  = pend_addr ^ KEY;
                end
            end
            if (ibus_req) begin
                cnt       = lat;
                pend_addr = ibus_addr;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] d, input logic [31:0] a, input logic v);
        check({tag, ".data"}, IF_inst_data, d);
        check({tag, ".addr"}, IF_inst_addr, a);
        check({tag, ".valid"}, {31'h0, IF_inst_valid}, {31'h0, v});
    endtask

    task automatic expect_nop(input string tag);
        check({tag, ".data"}, IF_inst_data, NOP);
        check({tag, ".valid"}, {31'h0, IF_inst_valid}, 32'h0);
    endtask

    task automatic expect_req(input string tag, input logic r, input logic [31:0] a);
        check({tag, ".req"}, {31'h0, ibus_req}, {31'h0, r});
        if (r) check({tag, ".req_addr"}, ibus_addr, a);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; hold_flag = HOLD_NONE; jump_flag = 1'b0; jump_addr = 32'h0;
        tick(2);
        expect_out("reset", NOP, 32'h0, 1'b0);
        check("reset.req", {31'h0, ibus_req}, 32'h0);
        check("reset.req_addr", ibus_addr, 32'h0);
        rst_n = 1'b1;

        // Zero-wait stream: one instruction every second cycle.
        tick(1); expect_req("n0", 1'b1, 32'h0);
        tick(1); expect_req("n1", 1'b0, 32'h0);
        tick(1); expect_out("n2", KEY ^ 32'h0, 32'h0, 1'b1); expect_req("n2", 1'b1, 32'h4);
        tick(1); expect_nop("n3");
        tick(1); expect_out("n4", KEY ^ 32'h4, 32'h4, 1'b1); expect_req("n4", 1'b1, 32'h8);

        // Hold_ID for five edges: 0x8 lands in the skid buffer.
        hold_flag = HOLD_ID;
        tick(2); expect_out("hold6", KEY ^ 32'h4, 32'h4, 1'b1); expect_req("hold6", 1'b0, 32'h0);
        tick(3); expect_out("hold9", KEY ^ 32'h4, 32'h4, 1'b1); expect_req("hold9", 1'b0, 32'h0);
        hold_flag = HOLD_NONE;
        tick(1); expect_out("rel10", KEY ^ 32'h8, 32'h8, 1'b1); expect_req("rel10", 1'b0, 32'h0);
        tick(1); expect_nop("rel11"); expect_req("rel11", 1'b1, 32'hC);
        tick(1); lat = 3;
        tick(1); expect_out("rel13", KEY ^ 32'hC, 32'hC, 1'b1); expect_req("rel13", 1'b1, 32'h10);

        // Jump while 0x10 is outstanding: its response must be dropped.
        tick(1); expect_nop("j14"); jump_flag = 1'b1; jump_addr = 32'h100;
        tick(1); jump_flag = 1'b0; expect_nop("j15");
        tick(1); expect_nop("j16"); expect_req("j16", 1'b0, 32'h0);
        tick(1); expect_nop("j17"); expect_req("j17", 1'b1, 32'h100);
        tick(1); lat = 1;
        tick(3); expect_out("j21", KEY ^ 32'h100, 32'h100, 1'b1); expect_req("j21", 1'b1, 32'h104);

        // Jump coinciding with rvalid of 0x104.
        tick(1); jump_flag = 1'b1; jump_addr = 32'h200;
        tick(1); jump_flag = 1'b0; expect_nop("jr23"); expect_req("jr23", 1'b1, 32'h200);

        // Response into an empty output under Hold_PPL, then a jump flushes it.
        tick(1); hold_flag = HOLD_PPL;
        tick(1); expect_out("ppl25", KEY ^ 32'h200, 32'h200, 1'b1); expect_req("ppl25", 1'b0, 32'h0);
        jump_flag = 1'b1; jump_addr = 32'h300;
        tick(1); jump_flag = 1'b0; expect_nop("ppl26"); expect_req("ppl26", 1'b0, 32'h0);
        tick(1); expect_req("ppl27", 1'b0, 32'h0); hold_flag = HOLD_NONE;
        tick(1); expect_req("ppl28", 1'b1, 32'h300);
        tick(2); expect_out("ppl30", KEY ^ 32'h300, 32'h300, 1'b1); expect_req("ppl30", 1'b1, 32'h304);

        // Hold_PC: the in-flight fetch completes and is consumed, nothing new is issued.
        hold_flag = HOLD_PC;
        tick(1); expect_nop("hpc31");
        tick(1); expect_out("hpc32", KEY ^ 32'h304, 32'h304, 1'b1); expect_req("hpc32", 1'b0, 32'h0);
        tick(1); expect_nop("hpc33"); expect_req("hpc33", 1'b0, 32'h0);
        tick(1); expect_req("hpc34", 1'b0, 32'h0); hold_flag = HOLD_NONE; lat = 3;
        tick(1); expect_req("hpc35", 1'b1, 32'h308);

        // Reset while waiting on a 3-cycle response.
        tick(4); expect_out("rs39", KEY ^ 32'h308, 32'h308, 1'b1); expect_req("rs39", 1'b1, 32'h30C);
        hold_flag = HOLD_ID;
        tick(2); expect_out("rs41", KEY ^ 32'h308, 32'h308, 1'b1); expect_req("rs41", 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        expect_out("rs_async", NOP, 32'h0, 1'b0);
        check("rs_async.req", {31'h0, ibus_req}, 32'h0);
        check("rs_async.req_addr", ibus_addr, 32'h0);
        tick(1); hold_flag = HOLD_NONE; rst_n = 1'b1;
        tick(1); expect_nop("rs43"); expect_req("rs43", 1'b1, 32'h0);
        tick(3); expect_nop("rs46");
        tick(1); expect_out("rs47", KEY ^ 32'h0, 32'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction fetch stage. Owns the PC and issues read requests on the instruction bus (req/gnt/rvalid).
- Presents one instruction per cycle on IF_inst_data/IF_inst_addr to the IF/ID pipeline register.
- Produces the values that the IF/ID register latches, and honours the same hold_flag and jump controls, so stalls and flushes never lose or duplicate an instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- NOP_INST, 32'h0000_0013, instruction driven when no valid fetch is present (addi x0,x0,0).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- hold_flag  in  `HOLDBUS (3)  pipeline hold code: Hold_None=0, Hold_PC=1, Hold_IF=2, Hold_ID=3, Hold_PPL=4.
- jump_flag  in  1  single-cycle redirect request from EX.
- jump_addr  in  32  redirect target; word aligned.
- ibus_req  out  1  fetch request.
- ibus_addr  out  32  fetch address.
- ibus_gnt  in  1  request accepted in this cycle (when ibus_req=1).
- ibus_rvalid  in  1  read data valid; exactly one per granted request, at least 1 cycle after gnt.
- ibus_rdata  in  32  instruction word.
- IF_inst_data  out  32  instruction to IF/ID.
- IF_inst_addr  out  32  PC of IF_inst_data.
- IF_inst_valid  out  1  IF_inst_data is a real fetched instruction.

Behaviour:
- Hold decode:
  - stall_out = hold_flag in {Hold_IF, Hold_ID, Hold_PPL}.
  - stop_issue = stall_out or hold_flag==Hold_PC.
  - Output is consumed at a clk edge iff stall_out=0.
- Reset values:
  - pc=RESET_PC; ibus_req=0; ibus_addr=RESET_PC.
  - IF_inst_data=NOP_INST; IF_inst_addr=0; IF_inst_valid=0.
  - Skid buffer empty; outstanding=0; drop=0; FSM=IDLE.
- Storage: output register (data/addr/valid) plus one-entry skid buffer. At most 1 outstanding request.
- FSM:
  - IDLE: go to REQ when !stop_issue and skid empty and outstanding=0.
  - REQ: ibus_req=1, ibus_addr=pc; addr stable until gnt. On gnt: pc<=pc+4 (mod 2^32), outstanding<=1, go to WAIT.
  - WAIT: on rvalid, outstanding<=0. Go to REQ the same edge if the issue condition holds, else IDLE.
- Response capture (rvalid, drop=0):
  - If output reg empty or being consumed: output <= {rdata, addr, valid=1}. IF_inst_data is valid the cycle after rvalid (1-cycle latency).
  - Else: write to skid buffer.
- Consume:
  - If skid is full: output <= skid, skid empties.
  - Else if no new data: output <= {NOP_INST, addr unchanged, valid=0}.
- Stall: output and skid hold their values indefinitely; no new request while skid is full.
- Jump (highest priority):
  - pc<=jump_addr; output <= NOP/valid=0; skid cleared.
  - If a request is outstanding or in REQ: drop<=1, and the next response is discarded. A REQ not yet granted keeps its old address until gnt.
  - An rvalid in the same cycle as jump is discarded.
  - drop clears on the discarded rvalid.
  - First fetch from jump_addr is issued afterwards.
- Jump while stall_out: flush still applies. The redirect wins; a stall only blocks issue.
- Back-to-back jumps: the latest jump_addr wins; drop stays 1 until the single outstanding response returns.
- Reset mid-transaction: all state returns to reset values immediately. The bus drops any outstanding response on reset (system reset).
- Throughput: 1 instruction per 2 cycles with zero-wait bus (gnt in the REQ cycle, rvalid next cycle).

Decomposition:
- Shared para file:
  - `HOLDBUS and Hold_* codes (shared with the IF/ID and ID/EX registers and the ctrl unit).
  - `DATABUS, `ADDRBUS.
  - INST_NOP.
- Sub-module fetch_skid: 1-entry buffer with push/pop/flush, 33-bit payload plus addr.
- FSM and PC stay in if_fetch.

Test Plan:
- Reset, zero-wait bus returning rdata=addr^32'hA5A5_0000 → requests at 0x0,0x4,0x8; IF_inst_data sequence 0xA5A5_0000, 0xA5A5_0004, each valid the cycle after rvalid, NOP between.
- hold_flag=Hold_ID for 5 cycles while rvalid arrives → output held at 0x4's instruction, 0x8's instruction sits in the skid; no req while skid full; after release, outputs 0x8 then 0xC in order, none lost or duplicated.
- jump_flag with jump_addr=0x100 while request to 0x10 is outstanding → 0x10 response discarded (IF_inst_valid stays 0), next ibus_addr=0x100, then IF_inst_addr=0x100.
- jump in the same cycle as rvalid, plus jump during Hold_PPL → rvalid data never reaches the output; output becomes NOP valid=0; fetch resumes at the target once hold clears.
- hold_flag=Hold_PC → current output consumed, no new ibus_req; pc unchanged; resumes on Hold_None.
- rst_n pulsed low while in WAIT with 3-cycle bus latency → outputs return to NOP/0/0 asynchronously; first post-reset request at RESET_PC.
